des_input_sequencer: RTL

Front-end controller for the DES encrypt/decrypt core on the board. It takes debounced pushbutton levels and 16 slide switches, and assembles a 64-bit key and a 64-bit data block in four 16-bit chunks each. It then launches the DES core with a one-cycle start pulse, waits for completion with a timeout, and holds the result for display. It sits between the debouncer instances and the DES datapath.

---
 rtl/des_input_sequencer_if.sv | 43 ++++
 rtl/des_input_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/des_input_sequencer_if.sv
// Bundle of the front-panel and DES-core signals used by des_input_sequencer.
// Purpose : groups the button/switch inputs, the core handshake and the
//           display outputs so they travel as one port.
// Signals : btn_load_n, btn_clear_n  debounced buttons (idle 1, pressed 0)
//           sw_chunk, sw_decrypt     slide switches
//           core_done, core_result   completion pulse and data from the core
//           key, data_in             assembled operands to the core
//           core_start, core_decrypt launch pulse and latched mode
//           result, result_valid     captured core output
//           busy, error, chunk_idx   status for LEDs
// Modports: slave  - the sequencer (consumes panel/core inputs)
//           master - whoever drives the panel and models the core
interface des_input_sequencer_if #(
  parameter int CHUNK_W = 16
);
  logic               btn_load_n;
  logic               btn_clear_n;
  logic [CHUNK_W-1:0] sw_chunk;
  logic               sw_decrypt;
  logic               core_done;
  logic [63:0]        core_result;
  logic [63:0]        key;
  logic [63:0]        data_in;
  logic               core_start;
  logic               core_decrypt;
  logic [63:0]        result;
  logic               result_valid;
  logic               busy;
  logic               error;
  logic [1:0]         chunk_idx;

  modport slave (
    input  btn_load_n, btn_clear_n, sw_chunk, sw_decrypt, core_done, core_result,
    output key, data_in, core_start, core_decrypt, result, result_valid,
           busy, error, chunk_idx
  );

  modport master (
    output btn_load_n, btn_clear_n, sw_chunk, sw_decrypt, core_done, core_result,
    input  key, data_in, core_start, core_decrypt, result, result_valid,
           busy, error, chunk_idx
  );
endinterface

// File: rtl/des_input_sequencer.sv
// Front-end controller for the DES core.
// Purpose : assembles a 64-bit key and a 64-bit data block from four
//           switch chunks each (MSB chunk first), launches the core with a
//           one-cycle start pulse, waits for completion with a timeout and
//           holds the result for display.
// Ports   : clk  system clock
//           rst  asynchronous active-low reset
//           bus  des_input_sequencer_if.slave (panel inputs, core handshake,
//                display outputs)
// Parameters: CHUNK_W chunk width (4 chunks fill 64 bits),
//             TIMEOUT_CYCLES max WAIT cycles, TMR_W timer width with
//             2**TMR_W > TIMEOUT_CYCLES.
module des_input_sequencer #(
  parameter int CHUNK_W        = 16,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TMR_W          = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  des_input_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_LOAD_KEY,
    S_LOAD_DATA,
    S_START,
    S_WAIT,
    S_SHOW,
    S_ERR
  } state_t;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t             state_q;
  logic [63:0]        key_q;
  logic [63:0]        data_q;
  logic [63:0]        result_q;
  logic [1:0]         chunk_idx_q;
  logic [TMR_W-1:0]   timer_q;
  logic               core_start_q;
  logic               core_decrypt_q;
  logic               result_valid_q;
  logic               error_q;
  logic               load_prev_q;
  logic               clear_prev_q;

  logic               load_press_d;
  logic               clear_press_d;
  logic [63:0]        key_d;
  logic [63:0]        data_d;
  logic [1:0]         chunk_idx_d;

  // Falling edge on the (already debounced) button levels; the previous
  // samples reset to 1 so a button held through reset is not a press.
  always_comb begin
    load_press_d  = load_prev_q  & ~bus.btn_load_n;
    clear_press_d = clear_prev_q & ~bus.btn_clear_n;
  end

  // Candidate registers with the current switch chunk dropped into the slot
  // selected by chunk_idx; chunk 0 lands in the top bits.
  always_comb begin
    key_d  = key_q;
    data_d = data_q;
    for (int i = 0; i < 4; i++) begin
      if (chunk_idx_q == 2'(i)) begin
        key_d[(3-i)*CHUNK_W +: CHUNK_W]  = bus.sw_chunk;
        data_d[(3-i)*CHUNK_W +: CHUNK_W] = bus.sw_chunk;
      end
    end
    chunk_idx_d = chunk_idx_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_LOAD_KEY;
      key_q          <= '0;
      data_q         <= '0;
      result_q       <= '0;
      chunk_idx_q    <= '0;
      timer_q        <= '0;
      core_start_q   <= 1'b0;
      core_decrypt_q <= 1'b0;
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
      load_prev_q    <= 1'b1;
      clear_prev_q   <= 1'b1;
    end else begin
      load_prev_q  <= bus.btn_load_n;
      clear_prev_q <= bus.btn_clear_n;

      if (clear_press_d) begin
        // Clear overrides any state and swallows a simultaneous load press.
        state_q        <= S_LOAD_KEY;
        key_q          <= '0;
        data_q         <= '0;
        result_q       <= '0;
        chunk_idx_q    <= '0;
        timer_q        <= '0;
        core_start_q   <= 1'b0;
        result_valid_q <= 1'b0;
        error_q        <= 1'b0;
      end else begin
        core_start_q <= 1'b0;
        unique case (state_q)
          S_LOAD_KEY: begin
            if (load_press_d) begin
              key_q       <= key_d;
              chunk_idx_q <= chunk_idx_d;
              if (chunk_idx_q == 2'd3) begin
                state_q <= S_LOAD_DATA;
              end
            end
          end

          S_LOAD_DATA: begin
            if (load_press_d) begin
              data_q      <= data_d;
              chunk_idx_q <= chunk_idx_d;
              if (chunk_idx_q == 2'd3) begin
                core_decrypt_q <= bus.sw_decrypt;
                core_start_q   <= 1'b1;   // high during the START cycle only
                state_q        <= S_START;
              end
            end
          end

          S_START: begin
            timer_q <= '0;
            state_q <= S_WAIT;
          end

          S_WAIT: begin
            // Completion is checked first so a done on the last timer
            // cycle still delivers its result.
            if (bus.core_done) begin
              result_q       <= bus.core_result;
              result_valid_q <= 1'b1;
              state_q        <= S_SHOW;
            end else if (timer_q == TMR_LAST) begin
              error_q <= 1'b1;
              state_q <= S_ERR;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end

          S_SHOW: begin
            // Key is kept: the next block is entered under the same key.
            if (load_press_d) begin
              result_valid_q <= 1'b0;
              chunk_idx_q    <= '0;
              state_q        <= S_LOAD_DATA;
            end
          end

          S_ERR: begin
            error_q <= 1'b1;
          end

          default: begin
            state_q <= S_LOAD_KEY;
          end
        endcase
      end
    end
  end

  assign bus.key          = key_q;
  assign bus.data_in      = data_q;
  assign bus.result       = result_q;
  assign bus.chunk_idx    = chunk_idx_q;
  assign bus.core_start   = core_start_q;
  assign bus.core_decrypt = core_decrypt_q;
  assign bus.result_valid = result_valid_q;
  assign bus.error        = error_q;
  assign bus.busy         = (state_q == S_START) || (state_q == S_WAIT);

endmodule
